// File: rtl/fpu_sign_resolve.sv
// Two-stage valid/ready pipeline that resolves the IEEE result sign of an FPU
// add/mul/fused op from operand signs and adder magnitude flags.
module fpu_sign_resolve #(
    parameter int TAG_W   = 4,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op_type,
    input  logic               xs,
    input  logic               ys,
    input  logic               zs,
    input  logic               add_neg,
    input  logic               add_zero,
    input  logic               res_nan,
    input  logic [2:0]         rm,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign,
    output logic               out_prod_sign,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal,
    output logic [STALL_W-1:0] stall_cnt
);
    // Handshake: a beat transfers on an edge where valid && ready are both 1;
    // valid and payload stay stable until that edge, ready may change freely.
    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_FMA    = 3'b011;
    localparam logic [2:0] OP_FMS    = 3'b100;
    localparam logic [2:0] OP_FNMADD = 3'b101;
    localparam logic [2:0] OP_FNMSUB = 3'b110;
    localparam logic [2:0] RM_RDN    = 3'b010;
    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    logic w_s1_en, w_s2_en;
    logic w_prod, w_a_sign, w_b_sign, w_is_mul, w_illegal;
    logic w_s2_sign;

    logic             r_s1_valid, r_s1_a_sign, r_s1_b_sign, r_s1_prod, r_s1_illegal;
    logic             r_s1_is_mul, r_s1_add_neg, r_s1_add_zero, r_s1_res_nan;
    logic [2:0]       r_s1_rm;
    logic [TAG_W-1:0] r_s1_tag;

    logic               r_s2_valid, r_s2_sign, r_s2_prod, r_s2_illegal;
    logic [TAG_W-1:0]   r_s2_tag;
    logic [STALL_W-1:0] r_stall_cnt;

    assign w_s2_en  = !r_s2_valid || out_ready;
    assign w_s1_en  = !r_s1_valid || w_s2_en;
    assign in_ready = w_s1_en;

    // Negation of fused ops is folded into the term signs before the add.
    always_comb begin
        w_prod    = xs ^ ys;
        w_a_sign  = 1'b0;
        w_b_sign  = 1'b0;
        w_is_mul  = 1'b0;
        w_illegal = 1'b0;
        case (op_type)
            OP_ADD:    begin w_a_sign = xs;      w_b_sign = ys;  end
            OP_SUB:    begin w_a_sign = xs;      w_b_sign = ~ys; end
            OP_MUL:    begin w_a_sign = w_prod;  w_is_mul = 1'b1; end
            OP_FMA:    begin w_a_sign = w_prod;  w_b_sign = zs;  end
            OP_FMS:    begin w_a_sign = w_prod;  w_b_sign = ~zs; end
            OP_FNMADD: begin w_a_sign = ~w_prod; w_b_sign = ~zs; end
            OP_FNMSUB: begin w_a_sign = ~w_prod; w_b_sign = zs;  end
            default:   w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_s2_sign = 1'b0;
        if (r_s1_illegal || r_s1_res_nan)
            w_s2_sign = 1'b0;
        else if (r_s1_is_mul)
            w_s2_sign = r_s1_prod;
        else if (r_s1_add_zero && (r_s1_a_sign == r_s1_b_sign))
            w_s2_sign = r_s1_a_sign;
        else if (r_s1_add_zero)
            w_s2_sign = (r_s1_rm == RM_RDN);
        else
            w_s2_sign = r_s1_add_neg ? r_s1_b_sign : r_s1_a_sign;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_a_sign   <= 1'b0;
            r_s1_b_sign   <= 1'b0;
            r_s1_prod     <= 1'b0;
            r_s1_illegal  <= 1'b0;
            r_s1_is_mul   <= 1'b0;
            r_s1_add_neg  <= 1'b0;
            r_s1_add_zero <= 1'b0;
            r_s1_res_nan  <= 1'b0;
            r_s1_rm       <= 3'b000;
            r_s1_tag      <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a_sign   <= w_a_sign;
                r_s1_b_sign   <= w_b_sign;
                r_s1_prod     <= w_prod;
                r_s1_illegal  <= w_illegal;
                r_s1_is_mul   <= w_is_mul;
                r_s1_add_neg  <= add_neg;
                r_s1_add_zero <= add_zero;
                r_s1_res_nan  <= res_nan;
                r_s1_rm       <= rm;
                r_s1_tag      <= in_tag;
            end
        end
    end

    // Stage 2 only loads when it can hand off, so outputs hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_sign    <= 1'b0;
            r_s2_prod    <= 1'b0;
            r_s2_illegal <= 1'b0;
            r_s2_tag     <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign    <= w_s2_sign;
                r_s2_prod    <= r_s1_prod;
                r_s2_illegal <= r_s1_illegal;
                r_s2_tag     <= r_s1_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (r_s2_valid && !out_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + STALL_ONE;
    end

    assign out_valid     = r_s2_valid;
    assign out_sign      = r_s2_sign;
    assign out_prod_sign = r_s2_prod;
    assign out_tag       = r_s2_tag;
    assign out_illegal   = r_s2_illegal;
    assign stall_cnt     = r_stall_cnt;
endmodule

// File: tb/tb_fpu_sign_resolve.sv
// Bench for fpu_sign_resolve: directed vectors feed an expected queue that a
// separate monitor drains on every output handshake.
module tb_fpu_sign_resolve;
    localparam int TAG_W   = 4;
    localparam int STALL_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [2:0]         op_type = 3'b000;
    logic               xs = 1'b0, ys = 1'b0, zs = 1'b0;
    logic               add_neg = 1'b0, add_zero = 1'b0, res_nan = 1'b0;
    logic [2:0]         rm = 3'b000;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               out_sign, out_prod_sign, out_illegal;
    logic [TAG_W-1:0]   out_tag;
    logic [STALL_W-1:0] stall_cnt;

    // {sign, prod_sign, illegal, tag}
    logic [TAG_W+2:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    fpu_sign_resolve #(.TAG_W(TAG_W), .STALL_W(STALL_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_type(op_type), .xs(xs), .ys(ys), .zs(zs),
        .add_neg(add_neg), .add_zero(add_zero), .res_nan(res_nan), .rm(rm),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_prod_sign(out_prod_sign), .out_tag(out_tag),
        .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives one op at a negedge and holds it until accepted; returns at the accepting edge.
    task automatic send(input logic [2:0] op, input logic x, input logic y, input logic z,
                        input logic neg, input logic zero, input logic nan,
                        input logic [2:0] r, input logic [TAG_W-1:0] tag,
                        input logic e_sign, input logic e_ill);
        logic acc;
        int   n;
        @(negedge clk);
        in_valid = 1'b1; op_type = op; xs = x; ys = y; zs = z;
        add_neg = neg; add_zero = zero; res_nan = nan; rm = r; in_tag = tag;
        n = 0;
        forever begin
            #4;
            acc = in_ready;
            if (acc) exp_q.push_back({e_sign, x ^ y, e_ill, tag});
            @(posedge clk);
            if (acc) break;
            n++;
            if (n > 40) begin
                checks++; errors++;
                $display("FAIL accept_timeout tag=%0d", tag);
                break;
            end
            @(negedge clk);
        end
        n_acc++;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d left required=0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: samples just before the rising edge, where an output handshake completes.
    always begin
        logic [TAG_W+2:0] e;
        @(negedge clk);
        #4;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual tag=%0d required none", out_tag);
            end else begin
                e = exp_q.pop_front();
                if ({out_sign, out_prod_sign, out_illegal, out_tag} !== e) begin
                    errors++;
                    $display("FAIL result tag=%0d actual s/p/i=%b%b%b required s/p/i/tag=%b%b%b/%0d",
                             out_tag, out_sign, out_prod_sign, out_illegal,
                             e[TAG_W+2], e[TAG_W+1], e[TAG_W], e[TAG_W-1:0]);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sign", 32'(out_sign), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // FMA 0*1+0, addend larger: latency check then a stream of directed vectors
        send(3'b011, 0, 1, 0, 1, 0, 0, 3'b000, 4'd1, 1'b0, 1'b0);
        idle();
        chk("latency_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_cycle2", 32'(out_valid), 32'd1);

        send(3'b011, 0, 0, 1, 0, 1, 0, 3'b000, 4'd2, 1'b0, 1'b0); // exact zero, RNE
        send(3'b011, 0, 0, 1, 0, 1, 0, 3'b010, 4'd3, 1'b1, 1'b0); // exact zero, RDN
        send(3'b101, 0, 0, 1, 0, 1, 0, 3'b000, 4'd4, 1'b0, 1'b0); // FNMADD zero
        send(3'b101, 0, 0, 0, 0, 0, 0, 3'b000, 4'd5, 1'b1, 1'b0); // FNMADD pre-negated
        send(3'b111, 1, 0, 0, 0, 0, 0, 3'b000, 4'd6, 1'b0, 1'b1); // illegal
        send(3'b010, 1, 0, 0, 0, 0, 1, 3'b000, 4'd7, 1'b0, 1'b0); // MUL NaN
        send(3'b010, 1, 0, 0, 1, 1, 0, 3'b010, 4'd8, 1'b1, 1'b0); // MUL ignores adder flags
        send(3'b000, 1, 1, 0, 0, 1, 0, 3'b000, 4'd9, 1'b1, 1'b0); // -x + -y exact zero
        send(3'b001, 1, 1, 0, 1, 0, 0, 3'b000, 4'd10, 1'b0, 1'b0);
        send(3'b001, 1, 0, 0, 0, 0, 0, 3'b000, 4'd11, 1'b1, 1'b0);
        send(3'b100, 1, 0, 1, 1, 0, 0, 3'b000, 4'd12, 1'b0, 1'b0);
        send(3'b110, 1, 1, 1, 1, 0, 0, 3'b000, 4'd13, 1'b1, 1'b0);
        send(3'b110, 0, 1, 0, 0, 1, 0, 3'b010, 4'd14, 1'b0, 1'b0);
        send(3'b000, 0, 1, 0, 0, 1, 0, 3'b011, 4'd15, 1'b0, 1'b0); // RUP, opposite signs
        send(3'b011, 1, 1, 1, 1, 0, 1, 3'b010, 4'd0, 1'b0, 1'b0);  // FMA NaN
        idle();
        drain();
        chk("no_stall_streaming", 32'(stall_cnt), 32'd0);

        // Backpressure: four ops, sink blocked for five stalled cycles
        do_reset();
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int t = 1; t <= 4; t++)
                    send(3'b011, 0, 0, 0, 0, 0, 0, 3'b000, TAG_W'(t), 1'b0, 1'b0);
                idle();
            end
            begin
                int k;
                k = 0;
                while (!out_valid && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
                chk("bp_in_ready_full", 32'(in_ready), 32'd0);
                chk("bp_accepts_before_full", 32'(n_acc), 32'd2);
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("bp_stall_cnt", 32'(stall_cnt), 32'd5);
                chk("bp_held_tag", 32'(out_tag), 32'd1);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_stall_kept", 32'(stall_cnt), 32'd5);

        // Saturation, then reset with two ops in flight
        do_reset();
        out_ready = 1'b0;
        send(3'b000, 1, 1, 0, 0, 0, 0, 3'b000, 4'd5, 1'b1, 1'b0);
        send(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 4'd6, 1'b0, 1'b0);
        idle();
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        chk("sat_held_valid", 32'(out_valid), 32'd1);
        chk("sat_held_tag", 32'(out_tag), 32'd5);
        chk("sat_held_sign", 32'(out_sign), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        in_valid = 1'b1; op_type = 3'b000; in_tag = 4'd7;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (8) @(negedge clk);
        chk("midrst_no_output", 32'(out_valid), 32'd0);
        chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_sign_resolve.md
FPU_SIGN_RESOLVE -- requirements
Module: fpu_sign_resolve

Interface
REQ-001 Parameter: TAG_W, default 4, width of the transaction tag carried alongside each operation.
REQ-002 Parameter: STALL_W, default 16, width of the saturating backpressure stall counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream operation present.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 op_type  input  3  000 ADD, 001 SUB, 010 MUL, 011 FMA, 100 FMS, 101 FNMADD, 110 FNMSUB; 111 illegal.
REQ-008 xs, ys, zs  input  1 each  operand signs X, Y, Z.
REQ-009 add_neg  input  1  adder reports |addend| > |first term|, so the magnitude result takes the addend sign.
REQ-010 add_zero  input  1  adder result exactly zero.
REQ-011 res_nan  input  1  result is NaN.
REQ-012 rm  input  3  RISC-V rounding mode; 010 = RDN.
REQ-013 in_tag  input  TAG_W  opaque tag.
REQ-014 out_valid  output  1  resolved result present.
REQ-015 out_ready  input  1  downstream accepts.
REQ-016 out_sign  output  1  final IEEE result sign.
REQ-017 out_prod_sign  output  1  xs^ys of the same transaction.
REQ-018 out_tag  output  TAG_W  tag of the same transaction.
REQ-019 out_illegal  output  1  op_type was 111.
REQ-020 stall_cnt  output  STALL_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-021 Two-stage valid/ready pipeline: s2_en = !s2_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en (combinational).
REQ-022 Transfer occurs on in_valid&in_ready (input) and out_valid&out_ready (output); latency 2 cycles with out_ready held high; throughput 1 per cycle.
REQ-023 Stage 1 registers: a_sign, b_sign (effective addend sign), prod_sign, illegal, is_mul, add_neg, add_zero, res_nan, rm, tag.
REQ-024 ADD: a_sign = xs, b_sign = ys. SUB: a_sign = xs, b_sign = ~ys.
REQ-025 FMA: a_sign = xs^ys, b_sign = zs. FMS: a_sign = xs^ys, b_sign = ~zs.
REQ-026 FNMADD: a_sign = ~(xs^ys), b_sign = ~zs. FNMSUB: a_sign = ~(xs^ys), b_sign = zs. Negation is applied before addition, never after.
REQ-027 Stage 2 sign, in priority order: illegal -> 0; res_nan -> 0 (canonical NaN); MUL -> xs^ys.
REQ-028 Continuing stage 2 priority: add_zero with a_sign == b_sign -> a_sign.
REQ-029 Continuing stage 2 priority: add_zero with a_sign != b_sign -> 1 if rm == 010, else 0.
REQ-030 Otherwise: add_neg ? b_sign : a_sign.
REQ-031 For MUL, add_neg and add_zero are ignored.
REQ-032 Stage 2 holds out_sign, out_prod_sign, out_tag and out_illegal stable while out_valid=1 and out_ready=0.
REQ-033 Full pipeline with out_ready=0: in_ready=0, no input is lost and no input is duplicated.
REQ-034 Simultaneous output drain and input accept on a full pipeline: both stages advance in the same cycle with no bubble.
REQ-035 stall_cnt increments each cycle out_valid & !out_ready, and saturates at all-ones (no wrap).
REQ-036 stall_cnt is never cleared except by rst.

Reset
REQ-037 rst=1 at a clock edge: s1_valid, s2_valid, out_valid, out_sign, out_prod_sign, out_illegal, out_tag and stall_cnt all become 0.
REQ-038 Reset mid-operation discards in-flight transactions, with no output for them after reset.
REQ-039 in_ready is 1 in the first cycle after reset deasserts.
REQ-040 Inputs presented while rst=1 are not captured.

Verification
REQ-041 FMA, xs=0 ys=1 zs=0, add_neg=1, add_zero=0, out_ready=1 -> out_sign=0, out_prod_sign=1, out_valid exactly 2 cycles after accept.
REQ-042 FMA, xs=0 ys=0 zs=1, add_zero=1: rm=000 -> out_sign=0; rm=010 -> out_sign=1. FNMADD same signs with rm=000 and add_zero=1 -> out_sign=0. FNMADD xs=0 ys=0 zs=0, add_zero=0, add_neg=0 -> out_sign=1.
REQ-043 Backpressure: 4 back-to-back ops with tags 1..4, out_ready=0 for 5 cycles then 1 -> in_ready drops after 2 accepts, tags emerge in order 1,2,3,4, stall_cnt=5.
REQ-044 op_type=111 -> out_illegal=1, out_sign=0. res_nan=1 with xs=1 under MUL -> out_sign=0.
REQ-045 Saturation: STALL_W=4 with 20 stall cycles -> stall_cnt=15. Then rst asserted with 2 ops in flight -> out_valid=0 and stall_cnt=0 next cycle, and neither op ever appears.
